display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digit positions (range 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (> DEAD_CYCLES).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2, anti-ghosting cycles at slot start with all digits off.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64, frames per blink phase (>= 1).
REQ-005 SHALL have parameter BLANK_CODE, default 4'd15, char code that selects the decoder default (blank).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port load_valid, input, 1, a new message is offered.
REQ-009 SHALL have port load_ready, output, 1, the shadow buffer can accept a message.
REQ-010 SHALL have port load_chars, input, 4*NUM_DIGITS, message; nibble k (bits 4k+3:4k) is digit k.
REQ-011 SHALL have port blink_mask, input, NUM_DIGITS, bit k set means digit k blinks.
REQ-012 SHALL have port char_sel, output, 4, char code for the downstream 7-segment decoder.
REQ-013 SHALL have port digit_en, output, NUM_DIGITS, one-hot active-high digit enable.
REQ-014 SHALL have port frame_done, output, 1, marks the last cycle of a full scan frame.

Function
REQ-015 SHALL keep slot counter cnt (0..REFRESH_DIV-1) and digit index idx (0..NUM_DIGITS-1); cnt increments every cycle.
REQ-016 SHALL, when cnt==REFRESH_DIV-1, wrap cnt to 0 and advance idx; idx==NUM_DIGITS-1 wraps to 0.
REQ-017 SHALL drive frame_done=1 exactly when cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1, else 0.
REQ-018 SHALL drive digit_en = one-hot(idx) when cnt>=DEAD_CYCLES, else all zero.
REQ-019 SHALL drive char_sel = active buffer nibble idx, passed unmodified (0..15), except as REQ-024.
REQ-020 SHALL derive char_sel, digit_en, frame_done only from registered state (no input-to-output path).
REQ-021 SHALL complete a handshake when load_valid && load_ready at a rising edge: shadow <= load_chars, pending <= 1.
REQ-022 SHALL drive load_ready = !pending; load_valid while load_ready=0 is ignored, shadow unchanged.
REQ-023 SHALL, at the edge ending a frame (frame_done=1) with pending=1, copy shadow to active and clear pending; active never changes mid-frame.
REQ-024 SHALL keep blink phase bit ph and frame counter fc; at each frame end fc increments, and at BLINK_FRAMES-1 wraps to 0 and toggles ph; while ph=1 and blink_mask[idx]=1, char_sel=BLANK_CODE.
REQ-025 SHALL, when a handshake and a frame end coincide with pending=0, capture into shadow and set pending; the copy occurs at the following frame end (no bypass).
REQ-026 SHALL sample blink_mask each cycle combinationally against registered idx/ph, but register char_sel so it changes only on clock edges.

Reset
REQ-027 SHALL, while rst_n=0, immediately force cnt=0, idx=0, fc=0, ph=0, pending=0, active and shadow all BLANK_CODE.
REQ-028 SHALL, in reset, output digit_en=0, char_sel=BLANK_CODE, frame_done=0, load_ready=1; handshakes ignored.
REQ-029 SHALL, on rst_n assertion mid-frame or mid-handshake, discard pending message and restart the scan at idx 0 after deassertion.

Verification (REFRESH_DIV=4, DEAD_CYCLES=1, NUM_DIGITS=4, BLINK_FRAMES=2)
REQ-030 SHALL cover post-reset scan: no load -> char_sel=15 always; digit_en pattern 0,1,1,1 per slot cycling 0001,0010,0100,1000; frame_done high every 16th cycle.
REQ-031 SHALL cover load and swap: load_chars=16'h8321 accepted mid-frame -> load_ready=0, char_sel stays 15 until frame end, next frame char_sel 1,2,3,8 for digits 0..3, load_ready returns 1.
REQ-032 SHALL cover backpressure: second load_valid with 16'h4444 while pending -> ignored; after swap, next frame shows the first message only.
REQ-033 SHALL cover coincident load on frame_done cycle -> shown one frame later, not immediately.
REQ-034 SHALL cover blink: blink_mask=4'b0010, message 16'h8321 -> digit 1 shows 2 for 2 frames, 15 for 2 frames, repeating; other digits unaffected.
REQ-035 SHALL cover mid-frame reset: rst_n low at idx=2 with pending=1 -> outputs to reset values at once; after release scan restarts at digit 0 showing 15, load_ready=1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices NUM_DIGITS digits with
// dead-time anti-ghosting, a double-buffered message and per-digit blinking.
module display_scan_ctrl #(
    parameter int         NUM_DIGITS   = 4,
    parameter int         REFRESH_DIV  = 50000,
    parameter int         DEAD_CYCLES  = 2,
    parameter int         BLINK_FRAMES = 64,
    parameter logic [3:0] BLANK_CODE   = 4'd15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_chars,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [3:0]                char_sel,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [4*NUM_DIGITS-1:0] BLANK_MSG = {NUM_DIGITS{BLANK_CODE}};

    logic [CW-1:0]            r_cnt;
    logic [IW-1:0]            r_idx;
    logic [FW-1:0]            r_fc;
    logic                     r_ph;
    logic                     r_pending;
    logic [4*NUM_DIGITS-1:0]  r_shadow;
    logic [4*NUM_DIGITS-1:0]  r_active;
    logic [3:0]               r_char_sel;

    logic                     w_slot_end;
    logic                     w_frame_end;
    logic                     w_handshake;
    logic                     w_blank;
    logic [3:0]               w_cur_char;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_handshake = load_valid && !r_pending;
    assign w_blank     = r_ph && blink_mask[r_idx];
    assign w_cur_char  = r_active[4*r_idx +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A handshake needs pending=0 and a swap needs pending=1, so the two never
    // collide; a load landing on the frame-end edge waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_shadow  <= BLANK_MSG;
            r_active  <= BLANK_MSG;
        end else if (w_handshake) begin
            r_shadow  <= load_chars;
            r_pending <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc <= '0;
            r_ph <= 1'b0;
        end else if (w_frame_end) begin
            if (r_fc == FC_LAST) begin
                r_fc <= '0;
                r_ph <= ~r_ph;
            end else begin
                r_fc <= r_fc + 1'b1;
            end
        end
    end

    // char_sel trails the scan state by one cycle; the dead time at slot
    // start hides the lag because digit_en is still off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_sel <= BLANK_CODE;
        end else begin
            r_char_sel <= w_blank ? BLANK_CODE : w_cur_char;
        end
    end

    always_comb begin
        digit_en = '0;
        if (r_cnt >= CNT_DEAD) begin
            digit_en = NUM_DIGITS'(1) << r_idx;
        end
    end

    assign char_sel   = r_char_sel;
    assign frame_done = w_frame_end;
    assign load_ready = !r_pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-count reference model pushes
// expected outputs per edge, a negedge monitor pops and compares.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_chars = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  char_sel;
    logic [3:0]  digit_en;
    logic        frame_done;

    display_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC),
        .BLINK_FRAMES(BF),
        .BLANK_CODE  (4'd15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_chars(load_chars),
        .blink_mask(blink_mask),
        .char_sel  (char_sel),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ch;
        logic [3:0] en;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: time since reset defines the scan position and blink phase.
    int unsigned m_t;
    bit          m_pend;
    logic [3:0]  m_shadow [N];
    logic [3:0]  m_active [N];
    logic [3:0]  m_ch;

    function automatic exp_t reset_exp();
        exp_t e;
        e.ch = 4'd15; e.en = 4'd0; e.fd = 1'b0; e.rdy = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_pend = 1'b0;
        m_ch = 4'd15;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 4'd15;
            m_active[k] = 4'd15;
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            if (clk) q.push_back(reset_exp());
            else q.delete();
        end else begin
            int unsigned cnt, idx, frm;
            bit fe, ph, was_pend;
            exp_t e;
            cnt = m_t % RD;
            idx = (m_t / RD) % N;
            frm = m_t / (RD * N);
            fe  = (cnt == RD - 1) && (idx == N - 1);
            ph  = ((frm / BF) % 2) == 1;
            m_ch = (ph && blink_mask[idx]) ? 4'd15 : m_active[idx];
            was_pend = m_pend;
            if (load_valid && !was_pend) begin
                for (int k = 0; k < N; k++) m_shadow[k] = load_chars[4*k +: 4];
                m_pend = 1'b1;
            end
            if (fe && was_pend) begin
                for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
                m_pend = 1'b0;
            end
            m_t++;
            cnt = m_t % RD;
            idx = (m_t / RD) % N;
            e.ch  = m_ch;
            e.en  = (cnt >= DC) ? 4'(1 << idx) : 4'd0;
            e.fd  = (cnt == RD - 1) && (idx == N - 1);
            e.rdy = !m_pend;
            q.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = q.pop_front();
            chk("char_sel",   int'(char_sel),   int'(e.ch));
            chk("digit_en",   int'(digit_en),   int'(e.en));
            chk("frame_done", int'(frame_done), int'(e.fd));
            chk("load_ready", int'(load_ready), int'(e.rdy));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_en(input logic [3:0] target);
        for (int i = 0; i < 200; i++) begin
            if (digit_en == target) return;
            cyc();
        end
        chk("wait_digit_en_timeout", int'(digit_en), int'(target));
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 200; i++) begin
            if (frame_done) return;
            cyc();
        end
        chk("wait_frame_done_timeout", int'(frame_done), 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (load_ready) return;
            cyc();
        end
        chk("wait_load_ready_timeout", int'(load_ready), 1);
    endtask

    task automatic offer(input logic [15:0] msg, input int n);
        load_chars = msg;
        load_valid = 1'b1;
        run(n);
        load_valid = 1'b0;
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;

        // Idle scan after reset: blank chars, dead-time digit pattern.
        run(40);

        // Mid-frame load, then a second offer while pending is ignored.
        wait_en(4'b0010);
        offer(16'h8321, 1);
        offer(16'h4444, 3);
        run(40);

        // Load coinciding with the frame-end edge appears one frame later.
        wait_fd();
        offer(16'h5678, 1);
        run(40);

        // Blink digit 1 across several blink periods.
        wait_ready();
        offer(16'h8321, 1);
        run(20);
        blink_mask = 4'b0010;
        run(160);
        blink_mask = 4'b0000;

        // Randomized traffic with occasional blink mask changes.
        for (int i = 0; i < 800; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_chars = 16'($urandom);
            if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
            cyc();
        end
        load_valid = 1'b0;
        blink_mask = 4'b0000;

        // Reset mid-frame with a message pending.
        wait_ready();
        wait_en(4'b0001);
        offer(16'h9abc, 1);
        wait_en(4'b0100);
        chk("pending_before_reset", int'(load_ready), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_char_sel",   int'(char_sel),   15);
        chk("rst_digit_en",   int'(digit_en),   0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_load_ready", int'(load_ready), 1);
        offer(16'h1111, 3);
        rst_n = 1'b1;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
